multicycle_control_unit: RTL and testbench

- Multicycle successor to the single-cycle control unit: a Moore FSM that sequences fetch, decode, execute, optional multiply, memory and writeback for RV32I, plus optional M-extension multiply.
- Waits on instruction and data memory with `ihit`/`dhit` handshakes.
- Includes a configurable memory-wait watchdog.
- Sits between the instruction register/ALU and the register file, PC and memory request logic of the multicycle datapath.

---
 rtl/cpu_types_pkg.sv | 48 ++++
 rtl/multicycle_control_if.sv | 38 +++
 rtl/alu_decoder.sv | 47 ++++
 rtl/multicycle_control_unit.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the multicycle RV32I control path: opcodes, ALU operations,
// FSM states, funct constants and the branch-resolution helper.
package cpu_types_pkg;

  typedef enum logic [6:0] {
    RTYPE = 7'b0110011,
    ITYPE = 7'b0010011,
    LW    = 7'b0000011,
    SW    = 7'b0100011,
    BTYPE = 7'b1100011,
    JAL   = 7'b1101111,
    JALR  = 7'b1100111,
    LUI   = 7'b0110111,
    AUIPC = 7'b0010111,
    HALT  = 7'b1111111
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } aluop_t;

  typedef enum logic [2:0] {
    RESET, FETCH, DECODE, EXEC, MULT, MEM, WB, HALTED
  } state_t;

  localparam logic [6:0] MUL_FUNCT7 = 7'h01;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // BEQ/BNE compare with SUB; the LT family with SLT/SLTU, where a nonzero result means "less than".
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
    logic taken;
    taken = 1'b0;
    case (f3)
      F3_BEQ, F3_BGE, F3_BGEU: taken = zero;
      F3_BNE, F3_BLT, F3_BLTU: taken = !zero;
      default:                 taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle of control-unit signals with a DUT-side and a bench-side view.
interface multicycle_control_if;
  import cpu_types_pkg::*;

  opcode_t    opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alu_zero;
  logic       ihit;
  logic       dhit;
  logic       iREN;
  logic       dREN;
  logic       dWEN;
  logic       IRWrite;
  logic       PCWrite;
  logic       PCSrc;
  logic       Jump;
  logic       ALUSrc;
  logic       MemtoReg;
  logic       RegWrite;
  aluop_t     aluop;
  logic       mul_start;
  logic       halt;
  logic       fault;
  state_t     state;

  modport control_unit (
    input  opcode, funct3, funct7, alu_zero, ihit, dhit,
    output iREN, dREN, dWEN, IRWrite, PCWrite, PCSrc, Jump, ALUSrc,
           MemtoReg, RegWrite, aluop, mul_start, halt, fault, state
  );

  modport control_unit_tb (
    output opcode, funct3, funct7, alu_zero, ihit, dhit,
    input  iREN, dREN, dWEN, IRWrite, PCWrite, PCSrc, Jump, ALUSrc,
           MemtoReg, RegWrite, aluop, mul_start, halt, fault, state
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational map from instruction fields to the ALU operation used in EXEC.
module alu_decoder
  import cpu_types_pkg::*;
(
  input  opcode_t    opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output aluop_t     aluop
);

  function automatic aluop_t arith_op(input logic [2:0] f3, input logic alt);
    aluop_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    aluop = ALU_ADD;
    case (opcode)
      RTYPE: begin
        // Multiplies bypass the ALU; keep it on a harmless ADD.
        if (funct7 == MUL_FUNCT7) aluop = ALU_ADD;
        else                      aluop = arith_op(funct3, funct7[5]);
      end
      ITYPE: aluop = arith_op(funct3, (funct3 == 3'b101) && funct7[5]);
      BTYPE: begin
        case (funct3)
          F3_BEQ, F3_BNE:   aluop = ALU_SUB;
          F3_BLT, F3_BGE:   aluop = ALU_SLT;
          F3_BLTU, F3_BGEU: aluop = ALU_SLTU;
          default:          aluop = ALU_ADD;
        endcase
      end
      default: aluop = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multicycle RV32I(+M) datapath: fetch, decode, execute,
// multiply, memory and writeback, with an optional memory-wait watchdog.
module multicycle_control_unit
  import cpu_types_pkg::*;
#(
  parameter int MULDIV_EN   = 1,
  parameter int MUL_LAT     = 4,
  parameter int WDOG_CYCLES = 0
) (
  input  logic       CLK,
  input  logic       nRST,
  input  opcode_t    opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       alu_zero,
  input  logic       ihit,
  input  logic       dhit,
  output logic       iREN,
  output logic       dREN,
  output logic       dWEN,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       Jump,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic       RegWrite,
  output aluop_t     aluop,
  output logic       mul_start,
  output logic       halt,
  output logic       fault,
  output state_t     state
);

  localparam logic [3:0]  MUL_LOAD  = 4'(MUL_LAT - 1);
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

  logic [3:0]  mul_cnt;
  logic [15:0] wait_cnt;
  logic        wdog_expire;
  logic        is_mul;
  logic        mul_op;
  logic        known_op;
  aluop_t      dec_aluop;

  alu_decoder u_alu_decoder (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .aluop  (dec_aluop)
  );

  assign is_mul      = (opcode == RTYPE) && (funct7 == MUL_FUNCT7);
  assign mul_op      = is_mul && (MULDIV_EN != 0);
  assign wdog_expire = (WDOG_CYCLES > 0) && (wait_cnt == WDOG_LAST);

  always_comb begin
    known_op = 1'b0;
    case (opcode)
      RTYPE, ITYPE, LW, SW, BTYPE, JAL, JALR, LUI, AUIPC: known_op = 1'b1;
      default: known_op = 1'b0;
    endcase
  end

  // Handshake: iREN (FETCH) and dREN/dWEN (MEM) are held until the matching
  // ihit/dhit is seen in that state; a hit in any other state is ignored, and
  // a hit on the watchdog's last cycle still completes the access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= RESET;
      mul_cnt  <= 4'd0;
      wait_cnt <= 16'd0;
      halt     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      case (state)
        RESET: begin
          state    <= FETCH;
          wait_cnt <= 16'd0;
        end
        FETCH: begin
          if (ihit) begin
            state    <= DECODE;
            wait_cnt <= 16'd0;
          end else if (wdog_expire) begin
            state    <= HALTED;
            halt     <= 1'b1;
            fault    <= 1'b1;
            wait_cnt <= 16'd0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        DECODE: begin
          if (opcode == HALT) begin
            state <= HALTED;
            halt  <= 1'b1;
          end else if (!known_op || (is_mul && MULDIV_EN == 0)) begin
            state <= HALTED;
            halt  <= 1'b1;
            fault <= 1'b1;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          case (opcode)
            LW, SW: begin
              state    <= MEM;
              wait_cnt <= 16'd0;
            end
            BTYPE: state <= FETCH;
            default: begin
              if (mul_op) begin
                state   <= MULT;
                mul_cnt <= MUL_LOAD;
              end else begin
                state <= WB;
              end
            end
          endcase
        end
        MULT: begin
          if (mul_cnt == 4'd0) state <= WB;
          else                 mul_cnt <= mul_cnt - 4'd1;
        end
        MEM: begin
          if (dhit) begin
            state    <= (opcode == LW) ? WB : FETCH;
            wait_cnt <= 16'd0;
          end else if (wdog_expire) begin
            state    <= HALTED;
            halt     <= 1'b1;
            fault    <= 1'b1;
            wait_cnt <= 16'd0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        WB:      state <= FETCH;
        HALTED:  state <= HALTED;
        default: state <= RESET;
      endcase
    end
  end

  always_comb begin
    iREN      = 1'b0;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    Jump      = 1'b0;
    ALUSrc    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    aluop     = ALU_ADD;
    mul_start = 1'b0;
    case (state)
      FETCH: begin
        iREN    = 1'b1;
        IRWrite = ihit;
      end
      EXEC: begin
        aluop     = dec_aluop;
        mul_start = mul_op;
        case (opcode)
          ITYPE, LW, SW, JALR, LUI, AUIPC: ALUSrc = 1'b1;
          default:                         ALUSrc = 1'b0;
        endcase
        if (opcode == BTYPE) begin
          PCWrite = 1'b1;
          PCSrc   = branch_taken(funct3, alu_zero);
        end
      end
      MEM: begin
        dREN    = (opcode == LW);
        dWEN    = (opcode == SW);
        PCWrite = (opcode == SW) && dhit;
      end
      WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        MemtoReg = (opcode == LW);
        Jump     = (opcode == JAL) || (opcode == JALR);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: per-cycle stimulus and hand-written expected state/output
// vectors, checked with immediate assertions against two parameterisations.
module tb_multicycle_control_unit;
  import cpu_types_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within its time bound");
    $fatal(1);
  end

  // ---------------- DUTs ----------------
  multicycle_control_if cu ();

  // dut_a: multiply enabled, MUL_LAT 4, watchdog 5
  multicycle_control_unit #(.MULDIV_EN(1), .MUL_LAT(4), .WDOG_CYCLES(5)) dut_a (
    .CLK(CLK), .nRST(nRST),
    .opcode(cu.opcode), .funct3(cu.funct3), .funct7(cu.funct7),
    .alu_zero(cu.alu_zero), .ihit(cu.ihit), .dhit(cu.dhit),
    .iREN(cu.iREN), .dREN(cu.dREN), .dWEN(cu.dWEN), .IRWrite(cu.IRWrite),
    .PCWrite(cu.PCWrite), .PCSrc(cu.PCSrc), .Jump(cu.Jump), .ALUSrc(cu.ALUSrc),
    .MemtoReg(cu.MemtoReg), .RegWrite(cu.RegWrite), .aluop(cu.aluop),
    .mul_start(cu.mul_start), .halt(cu.halt), .fault(cu.fault), .state(cu.state)
  );

  // dut_b: multiply disabled, watchdog disabled
  logic   b_iREN, b_dREN, b_dWEN, b_IRWrite, b_PCWrite, b_PCSrc, b_Jump;
  logic   b_ALUSrc, b_MemtoReg, b_RegWrite, b_mul_start, b_halt, b_fault;
  aluop_t b_aluop;
  state_t b_state;

  multicycle_control_unit #(.MULDIV_EN(0), .MUL_LAT(4), .WDOG_CYCLES(0)) dut_b (
    .CLK(CLK), .nRST(nRST),
    .opcode(cu.opcode), .funct3(cu.funct3), .funct7(cu.funct7),
    .alu_zero(cu.alu_zero), .ihit(cu.ihit), .dhit(cu.dhit),
    .iREN(b_iREN), .dREN(b_dREN), .dWEN(b_dWEN), .IRWrite(b_IRWrite),
    .PCWrite(b_PCWrite), .PCSrc(b_PCSrc), .Jump(b_Jump), .ALUSrc(b_ALUSrc),
    .MemtoReg(b_MemtoReg), .RegWrite(b_RegWrite), .aluop(b_aluop),
    .mul_start(b_mul_start), .halt(b_halt), .fault(b_fault), .state(b_state)
  );

  // Observed vectors: {state, aluop, 13 output flags}
  logic [19:0] a_vec, b_vec;
  assign a_vec = {cu.state, cu.aluop, cu.iREN, cu.dREN, cu.dWEN, cu.IRWrite,
                  cu.PCWrite, cu.PCSrc, cu.Jump, cu.ALUSrc, cu.MemtoReg,
                  cu.RegWrite, cu.mul_start, cu.halt, cu.fault};
  assign b_vec = {b_state, b_aluop, b_iREN, b_dREN, b_dWEN, b_IRWrite,
                  b_PCWrite, b_PCSrc, b_Jump, b_ALUSrc, b_MemtoReg,
                  b_RegWrite, b_mul_start, b_halt, b_fault};

  localparam logic [12:0] O_NONE = 13'h0000;
  localparam logic [12:0] O_IREN = 13'h1000;
  localparam logic [12:0] O_DREN = 13'h0800;
  localparam logic [12:0] O_DWEN = 13'h0400;
  localparam logic [12:0] O_IRW  = 13'h0200;
  localparam logic [12:0] O_PCW  = 13'h0100;
  localparam logic [12:0] O_PCS  = 13'h0080;
  localparam logic [12:0] O_JMP  = 13'h0040;
  localparam logic [12:0] O_ASRC = 13'h0020;
  localparam logic [12:0] O_M2R  = 13'h0010;
  localparam logic [12:0] O_RW   = 13'h0008;
  localparam logic [12:0] O_MST  = 13'h0004;
  localparam logic [12:0] O_HLT  = 13'h0002;
  localparam logic [12:0] O_FLT  = 13'h0001;

  // ---------------- scoreboard ----------------
  logic [19:0] exp_q[$];
  logic [2:0]  stim_q[$];
  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_instr(input opcode_t op, input logic [2:0] f3, input logic [6:0] f7);
    cu.opcode = op;
    cu.funct3 = f3;
    cu.funct7 = f7;
  endtask

  task automatic step(input logic ih, input logic dh, input logic z,
                      input state_t s, input aluop_t op, input logic [12:0] f);
    stim_q.push_back({ih, dh, z});
    exp_q.push_back({s, op, f});
  endtask

  // Inputs for each cycle are applied just after the edge that starts it.
  task automatic run_trace(input string tag);
    int n = 0;
    logic [19:0] e;
    while (exp_q.size() != 0) begin
      @(posedge CLK);
      #1;
      {cu.ihit, cu.dhit, cu.alu_zero} = stim_q.pop_front();
      e = exp_q.pop_front();
      #1;
      n++;
      chk($sformatf("%s c%0d", tag, n), a_vec, e);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    cu.ihit = 1'b0;
    cu.dhit = 1'b0;
    cu.alu_zero = 1'b0;
    #1;
    chk("reset dut_a", a_vec, {RESET, ALU_ADD, O_NONE});
    chk("reset dut_b", b_vec, {RESET, ALU_ADD, O_NONE});
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    nRST = 1'b0;
    cu.ihit = 1'b0;
    cu.dhit = 1'b0;
    cu.alu_zero = 1'b0;
    set_instr(RTYPE, 3'b000, 7'h00);

    // ADD, zero wait: RegWrite in cycle 4
    do_reset();
    step(1'b1, 1'b1, 1'b0, FETCH,  ALU_ADD, O_IREN | O_IRW);
    step(1'b1, 1'b1, 1'b0, DECODE, ALU_ADD, O_NONE);
    step(1'b1, 1'b1, 1'b0, EXEC,   ALU_ADD, O_NONE);
    step(1'b1, 1'b1, 1'b0, WB,     ALU_ADD, O_PCW | O_RW);
    step(1'b1, 1'b1, 1'b0, FETCH,  ALU_ADD, O_IREN | O_IRW);
    run_trace("add");

    // SRAI: ITYPE shift with alt bit, immediate operand
    set_instr(ITYPE, 3'b101, 7'h20);
    do_reset();
    step(1'b1, 1'b0, 1'b0, FETCH,  ALU_ADD, O_IREN | O_IRW);
    step(1'b0, 1'b0, 1'b0, DECODE, ALU_ADD, O_NONE);
    step(1'b0, 1'b0, 1'b0, EXEC,   ALU_SRA, O_ASRC);
    step(1'b0, 1'b0, 1'b0, WB,     ALU_ADD, O_PCW | O_RW);
    run_trace("srai");

    // LW with three dhit wait cycles: dREN for 4 cycles, WB at cycle 8
    set_instr(LW, 3'b010, 7'h00);
    do_reset();
    step(1'b1, 1'b0, 1'b0, FETCH,  ALU_ADD, O_IREN | O_IRW);
    step(1'b0, 1'b0, 1'b0, DECODE, ALU_ADD, O_NONE);
    step(1'b0, 1'b0, 1'b0, EXEC,   ALU_ADD, O_ASRC);
    step(1'b0, 1'b0, 1'b0, MEM,    ALU_ADD, O_DREN);
    step(1'b0, 1'b0, 1'b0, MEM,    ALU_ADD, O_DREN);
    step(1'b0, 1'b0, 1'b0, MEM,    ALU_ADD, O_DREN);
    step(1'b0, 1'b1, 1'b0, MEM,    ALU_ADD, O_DREN);
    step(1'b0, 1'b0, 1'b0, WB,     ALU_ADD, O_PCW | O_RW | O_M2R);
    step(1'b0, 1'b0, 1'b0, FETCH,  ALU_ADD, O_IREN);
    run_trace("lw_wait");

    // SW zero wait: PCWrite with dhit in MEM, back to FETCH
    set_instr(SW, 3'b010, 7'h00);
    do_reset();
    step(1'b1, 1'b1, 1'b0, FETCH,  ALU_ADD, O_IREN | O_IRW);
    step(1'b1, 1'b1, 1'b0, DECODE, ALU_ADD, O_NONE);
    step(1'b1, 1'b1, 1'b0, EXEC,   ALU_ADD, O_ASRC);
    step(1'b1, 1'b1, 1'b0, MEM,    ALU_ADD, O_DWEN | O_PCW);
    step(1'b1, 1'b1, 1'b0, FETCH,  ALU_ADD, O_IREN | O_IRW);
    run_trace("sw");

    // JAL: Jump in WB
    set_instr(JAL, 3'b000, 7'h00);
    do_reset();
    step(1'b1, 1'b0, 1'b0, FETCH,  ALU_ADD, O_IREN | O_IRW);
    step(1'b0, 1'b0, 1'b0, DECODE, ALU_ADD, O_NONE);
    step(1'b0, 1'b0, 1'b0, EXEC,   ALU_ADD, O_NONE);
    step(1'b0, 1'b0, 1'b0, WB,     ALU_ADD, O_PCW | O_RW | O_JMP);
    run_trace("jal");

    // BNE, alu_zero=0: taken
    set_instr(BTYPE, F3_BNE, 7'h00);
    do_reset();
    step(1'b1, 1'b0, 1'b0, FETCH,  ALU_ADD, O_IREN | O_IRW);
    step(1'b0, 1'b0, 1'b0, DECODE, ALU_ADD, O_NONE);
    step(1'b0, 1'b0, 1'b0, EXEC,   ALU_SUB, O_PCW | O_PCS);
    step(1'b0, 1'b0, 1'b0, FETCH,  ALU_ADD, O_IREN);
    run_trace("bne");

    // BEQ, alu_zero=0: not taken
    set_instr(BTYPE, F3_BEQ, 7'h00);
    do_reset();
    step(1'b1, 1'b0, 1'b0, FETCH,  ALU_ADD, O_IREN | O_IRW);
    step(1'b0, 1'b0, 1'b0, DECODE, ALU_ADD, O_NONE);
    step(1'b0, 1'b0, 1'b0, EXEC,   ALU_SUB, O_PCW);
    run_trace("beq");

    // BGE, alu_zero=0 (SLT result 1): not taken
    set_instr(BTYPE, F3_BGE, 7'h00);
    do_reset();
    step(1'b1, 1'b0, 1'b0, FETCH,  ALU_ADD, O_IREN | O_IRW);
    step(1'b0, 1'b0, 1'b0, DECODE, ALU_ADD, O_NONE);
    step(1'b0, 1'b0, 1'b0, EXEC,   ALU_SLT, O_PCW);
    run_trace("bge");

    // BLTU, alu_zero=0: taken
    set_instr(BTYPE, F3_BLTU, 7'h00);
    do_reset();
    step(1'b1, 1'b0, 1'b0, FETCH,  ALU_ADD, O_IREN | O_IRW);
    step(1'b0, 1'b0, 1'b0, DECODE, ALU_ADD, O_NONE);
    step(1'b0, 1'b0, 1'b0, EXEC,   ALU_SLTU, O_PCW | O_PCS);
    run_trace("bltu");

    // BGEU, alu_zero=1: taken
    set_instr(BTYPE, F3_BGEU, 7'h00);
    do_reset();
    step(1'b1, 1'b0, 1'b1, FETCH,  ALU_ADD, O_IREN | O_IRW);
    step(1'b0, 1'b0, 1'b1, DECODE, ALU_ADD, O_NONE);
    step(1'b0, 1'b0, 1'b1, EXEC,   ALU_SLTU, O_PCW | O_PCS);
    run_trace("bgeu");

    // MUL, MUL_LAT=4: mul_start in EXEC, four MULT cycles, WB at cycle 8
    set_instr(RTYPE, 3'b000, MUL_FUNCT7);
    do_reset();
    step(1'b1, 1'b0, 1'b0, FETCH,  ALU_ADD, O_IREN | O_IRW);
    step(1'b0, 1'b0, 1'b0, DECODE, ALU_ADD, O_NONE);
    step(1'b0, 1'b0, 1'b0, EXEC,   ALU_ADD, O_MST);
    step(1'b0, 1'b0, 1'b0, MULT,   ALU_ADD, O_NONE);
    step(1'b0, 1'b0, 1'b0, MULT,   ALU_ADD, O_NONE);
    step(1'b0, 1'b0, 1'b0, MULT,   ALU_ADD, O_NONE);
    step(1'b0, 1'b0, 1'b0, MULT,   ALU_ADD, O_NONE);
    step(1'b0, 1'b0, 1'b0, WB,     ALU_ADD, O_PCW | O_RW);
    step(1'b0, 1'b0, 1'b0, FETCH,  ALU_ADD, O_IREN);
    run_trace("mul");
    // Same instruction with multiply disabled: halted with fault after DECODE
    chk("nomul dut_b", b_vec, {HALTED, ALU_ADD, O_HLT | O_FLT});

    // Watchdog: 5 FETCH cycles without ihit, then HALTED with fault, no iREN
    set_instr(RTYPE, 3'b000, 7'h00);
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, FETCH, ALU_ADD, O_IREN);
    step(1'b0, 1'b0, 1'b0, HALTED, ALU_ADD, O_HLT | O_FLT);
    step(1'b1, 1'b0, 1'b0, HALTED, ALU_ADD, O_HLT | O_FLT);
    run_trace("wdog");
    chk("wdog off dut_b", b_vec, {FETCH, ALU_ADD, O_IREN | O_IRW});

    // Watchdog boundary: ihit on the limit cycle wins
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, FETCH, ALU_ADD, O_IREN);
    step(1'b1, 1'b0, 1'b0, FETCH,  ALU_ADD, O_IREN | O_IRW);
    step(1'b0, 1'b0, 1'b0, DECODE, ALU_ADD, O_NONE);
    run_trace("wdog_hit");

    // HALT opcode: sticky halt, stray hits ignored
    set_instr(HALT, 3'b000, 7'h00);
    do_reset();
    step(1'b1, 1'b0, 1'b0, FETCH,  ALU_ADD, O_IREN | O_IRW);
    step(1'b0, 1'b0, 1'b0, DECODE, ALU_ADD, O_NONE);
    step(1'b0, 1'b0, 1'b0, HALTED, ALU_ADD, O_HLT);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, HALTED, ALU_ADD, O_HLT);
    run_trace("halt");

    // Unknown opcode: halted with fault
    set_instr(opcode_t'(7'h55), 3'b000, 7'h00);
    do_reset();
    step(1'b1, 1'b0, 1'b0, FETCH,  ALU_ADD, O_IREN | O_IRW);
    step(1'b0, 1'b0, 1'b0, DECODE, ALU_ADD, O_NONE);
    step(1'b0, 1'b0, 1'b0, HALTED, ALU_ADD, O_HLT | O_FLT);
    run_trace("illegal");

    // Reset asserted mid-MEM: dREN drops at once, RESET then FETCH
    set_instr(LW, 3'b010, 7'h00);
    do_reset();
    step(1'b1, 1'b0, 1'b0, FETCH,  ALU_ADD, O_IREN | O_IRW);
    step(1'b0, 1'b0, 1'b0, DECODE, ALU_ADD, O_NONE);
    step(1'b0, 1'b0, 1'b0, EXEC,   ALU_ADD, O_ASRC);
    step(1'b0, 1'b0, 1'b0, MEM,    ALU_ADD, O_DREN);
    run_trace("lw_pre_rst");
    #2;
    nRST = 1'b0;
    #1;
    chk("mid rst dREN", cu.dREN, 1'b0);
    chk("mid rst vec", a_vec, {RESET, ALU_ADD, O_NONE});
    @(negedge CLK);
    nRST = 1'b1;
    step(1'b1, 1'b0, 1'b0, FETCH,  ALU_ADD, O_IREN | O_IRW);
    step(1'b0, 1'b0, 1'b0, DECODE, ALU_ADD, O_NONE);
    run_trace("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
